// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 read port (AR + R) among NUM_MST masters.
// One burst is in flight at a time; ownership ends on the RLAST handshake.
module axi_rd_arbiter #(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 4,
    parameter int DATA_W  = 128
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [NUM_MST-1:0]            m_arvalid,
    input  logic [NUM_MST*ADDR_W-1:0]     m_araddr,
    input  logic [NUM_MST*4-1:0]          m_arlen,
    input  logic [NUM_MST*3-1:0]          m_arsize,
    input  logic [NUM_MST*2-1:0]          m_arburst,
    input  logic [NUM_MST*ID_W-1:0]       m_arid,
    output logic [NUM_MST-1:0]            m_arready,
    output logic [NUM_MST-1:0]            m_rvalid,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [1:0]                    m_rresp,
    output logic [ID_W-1:0]               m_rid,
    output logic                          m_rlast,
    input  logic [NUM_MST-1:0]            m_rready,
    output logic                          s_arvalid,
    output logic [ADDR_W-1:0]             s_araddr,
    output logic [3:0]                    s_arlen,
    output logic [2:0]                    s_arsize,
    output logic [1:0]                    s_arburst,
    output logic [ID_W-1:0]               s_arid,
    input  logic                          s_arready,
    input  logic                          s_rvalid,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic [ID_W-1:0]               s_rid,
    input  logic                          s_rlast,
    output logic                          s_rready,
    output logic [$clog2(NUM_MST)-1:0]    grant,
    output logic                          busy,
    output logic                          err_stray_r
);

    localparam int GW = $clog2(NUM_MST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e        state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] rr_ptr_q;
    logic          err_q;
    logic [GW-1:0] pick_d;
    logic [GW-1:0] rr_ptr_d;
    logic          req_any_d;

    // Scan downward from the far end so the last hit is the first requester at or after rr_ptr.
    always_comb begin
        pick_d    = rr_ptr_q;
        req_any_d = 1'b0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_MST) begin
                idx = idx - NUM_MST;
            end
            if (m_arvalid[idx]) begin
                pick_d    = idx[GW-1:0];
                req_any_d = 1'b1;
            end
        end
    end

    assign rr_ptr_d = (int'(grant_q) == NUM_MST - 1) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (s_rvalid && (state_q != DATA)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (req_any_d) begin
                        grant_q <= pick_d;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (s_rvalid && m_rready[grant_q] && s_rlast) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        if (state_q == ADDR) begin
            m_arready[grant_q] = s_arready;
        end
        if (state_q == DATA) begin
            m_rvalid[grant_q] = s_rvalid;
        end
    end

    assign s_arvalid = (state_q == ADDR);
    assign s_araddr  = m_araddr[grant_q*ADDR_W +: ADDR_W];
    assign s_arlen   = m_arlen[grant_q*4 +: 4];
    assign s_arsize  = m_arsize[grant_q*3 +: 3];
    assign s_arburst = m_arburst[grant_q*2 +: 2];
    assign s_arid    = m_arid[grant_q*ID_W +: ID_W];

    assign s_rready  = (state_q == DATA) ? m_rready[grant_q] : 1'b0;
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rid     = s_rid;
    assign m_rlast   = s_rlast;

    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign err_stray_r = err_q;

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Round-robin arbiter that shares one AXI3-style read port (AR and R channels) of a slave among NUM_MST read masters in the AXI agent test environment. One burst is in flight at a time: the block grants one master, forwards its AR request, then routes R beats back to that master until the RLAST handshake, and only then re-arbitrates. It sits between the master-side agents and a single slave-side AXI interface instance.

## Interface
- NUM_MST, 2: number of requesting masters, legal range 2..4.
- ADDR_W, 32: AR address width.
- ID_W, 4: ARID/RID width, passed through unchanged.
- DATA_W, 128: RDATA width.
- clk  input  1  clock, all logic on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- m_arvalid  input  NUM_MST  per-master AR valid.
- m_araddr  input  NUM_MST*ADDR_W  per-master address; master i occupies bits [i*ADDR_W +: ADDR_W]. All packed buses use the same slicing.
- m_arlen  input  NUM_MST*4  burst length minus one.
- m_arsize  input  NUM_MST*3  beat size.
- m_arburst  input  NUM_MST*2  burst type.
- m_arid  input  NUM_MST*ID_W  transaction ID.
- m_arready  output  NUM_MST  per-master AR ready.
- m_rvalid  output  NUM_MST  per-master R valid.
- m_rdata  output  DATA_W  read data, shared by all masters; qualify with m_rvalid.
- m_rresp  output  2  response, shared.
- m_rid  output  ID_W  response ID, shared.
- m_rlast  output  1  last beat, shared.
- m_rready  input  NUM_MST  per-master R ready.
- s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid  output  1/ADDR_W/4/3/2/ID_W  slave AR channel.
- s_arready  input  1  slave AR ready.
- s_rvalid, s_rdata, s_rresp, s_rid, s_rlast  input  1/DATA_W/2/ID_W/1  slave R channel.
- s_rready  output  1  slave R ready.
- grant  output  $clog2(NUM_MST)  index of the current owner, registered.
- busy  output  1  high in ADDR or DATA.
- err_stray_r  output  1  sticky flag: s_rvalid was seen while not in DATA.

## Operation
- FSM states: IDLE, ADDR, DATA. Reset state is IDLE.
- IDLE, any m_arvalid set: select the first requester at or after rr_ptr, scanning upward with wrap at NUM_MST-1 to 0. Register that index into grant and move to ADDR. With no request, stay in IDLE.
- ADDR: s_arvalid=1. s_ar* fields are muxed combinationally from master[grant]. m_arready[grant]=s_arready; all other m_arready bits are 0. On s_arvalid&s_arready, move to DATA.
- DATA:
  - m_rvalid[grant]=s_rvalid and s_rready=m_rready[grant]; all other m_rvalid bits are 0.
  - s_rdata, s_rresp, s_rid and s_rlast pass to the shared m_r* outputs unchanged.
  - On a handshake with s_rlast=1: move to IDLE and set rr_ptr=grant+1, wrapping to 0.
- Outside DATA: s_rready=0 and all m_rvalid bits are 0.
- err_stray_r is set when s_rvalid=1 outside DATA. It stays set until reset.
- Burst length is not counted. RLAST alone ends ownership.
- A master must hold m_arvalid and its fields stable until m_arready, per AXI. If it drops m_arvalid in ADDR, that is a protocol violation and the block keeps s_arvalid asserted.

## Timing
- Values on reset: FSM=IDLE, grant=0, rr_ptr=0, busy=0, err_stray_r=0, s_arvalid=0, s_rready=0, m_arready=0, m_rvalid=0. Data outputs are don't-care.
- Latency from m_arvalid (sampled in IDLE) to s_arvalid is 1 cycle.
- R path has zero latency, combinational in both directions.
- After the RLAST handshake there is one IDLE cycle, then the next grant. Minimum spacing between s_arvalid assertions is burst beats + 2 cycles.
- When requests collide, round-robin fairness holds: a master waits for at most NUM_MST-1 bursts.
- Asserting aresetn=0 mid-burst returns the block to IDLE immediately and forces the reset values. The partial burst is abandoned.

## Test plan
- Single request: m_arvalid[0] with addr=0x1000, len=3, id=5. Required: s_arvalid one cycle later carrying addr 0x1000 and id 5, grant=0, four R beats delivered only to master 0, busy cleared after RLAST.
- Both masters request continuously, len=0 each, NUM_MST=2. Required: grants alternate 0,1,0,1, and each s_arvalid is separated by 3 cycles with zero-wait slave.
- Backpressure: s_arready low for 4 cycles, then m_rready[grant] low on beat 2. Required: AR fields stable throughout, beat 2 held until ready, and no beat is lost or duplicated.
- Stray R: s_rvalid=1 in IDLE. Required: s_rready=0, all m_rvalid=0, err_stray_r=1 from the next cycle until reset.
- Reset in DATA after beat 1 of len=7. Required: all outputs take reset values in the same cycle, and the first grant after reset goes to master 0.
- NUM_MST=4, requests from masters 1 and 3 with rr_ptr=2. Required: master 3 is granted first, then master 1.
